audio_mix_sequencer: RTL



---
 rtl/audio_mix_sequencer_pkg.sv | 25 ++
 rtl/audio_mix_sequencer_src_hold.sv | 47 ++++
 rtl/audio_mix_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/audio_mix_sequencer_pkg.sv
// Shared sample types and the saturating adder for the audio mix sequencer.
package audio_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned SLOT_BITS  = 18;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;

  // Add in DATA_WIDTH+1 bits and clamp to the representable range.
  function automatic sample_t sat_add(input sample_t a, input sample_t b);
    logic [DATA_WIDTH:0] sum;
    sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1]) begin
      return sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                             : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
    return sum[DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/audio_mix_sequencer_src_hold.sv
// One-deep holding slot for a stereo source: valid/ready capture, cleared at frame load.
module audio_src_hold
  import audio_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    en_i,
  input  logic    valid_i,
  input  sample_t l_i,
  input  sample_t r_i,
  input  logic    load_i,
  output logic    ready_c_o,
  output stereo_t contrib_c_o,
  output logic    starve_c_o
);

  logic    held_q, held_d;
  stereo_t data_q, data_d;
  logic    xfer;

  always_comb begin
    held_d      = held_q;
    data_d      = data_q;
    ready_c_o   = en_i & ~held_q;
    xfer        = valid_i & ready_c_o;
    // A transfer coinciding with a load refills the slot for the next frame.
    if (xfer) begin
      held_d = 1'b1;
      data_d = '{l: l_i, r: r_i};
    end else if (load_i) begin
      held_d = 1'b0;
    end
    contrib_c_o = (held_q & en_i) ? data_q : '0;
    starve_c_o  = en_i & ~held_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      held_q <= 1'b0;
      data_q <= '0;
    end else begin
      held_q <= held_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/audio_mix_sequencer.sv
// I2S transmitter: BCLK/LRCK divider, two-source saturating mixer and MSB-first serializer.
module audio_mix_sequencer
  import audio_pkg::*;
#(
  parameter int unsigned CLK_DIV = 6
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iEN_A,
  input  logic                  iVALID_A,
  output logic                  oREADY_A,
  input  logic [DATA_WIDTH-1:0] iL_A,
  input  logic [DATA_WIDTH-1:0] iR_A,
  input  logic                  iEN_B,
  input  logic                  iVALID_B,
  output logic                  oREADY_B,
  input  logic [DATA_WIDTH-1:0] iL_B,
  input  logic [DATA_WIDTH-1:0] iR_B,
  input  logic                  iCLR_ERR,
  output logic                  oBCLK,
  output logic                  oLRCK,
  output logic                  oDAT,
  output logic                  oFRAME,
  output logic                  oUNDERRUN
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(SLOT_BITS);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d, next_bit;
  logic             bclk_q, bclk_d;
  logic             lrck_q, lrck_d;
  logic             dat_q, dat_d;
  logic             frame_q, frame_d;
  logic             urun_q, urun_d;
  sample_t          shift_q, shift_d;
  sample_t          right_q, right_d;

  logic             div_wrap, fall_tick, bit_wrap, load;
  logic             starve_a, starve_b;
  stereo_t          contrib_a, contrib_b;
  sample_t          mix_l, mix_r;

  audio_src_hold u_src_a (
    .clk_i       (iCLK),
    .rst_i       (iRST),
    .en_i        (iEN_A),
    .valid_i     (iVALID_A),
    .l_i         (iL_A),
    .r_i         (iR_A),
    .load_i      (load),
    .ready_c_o   (oREADY_A),
    .contrib_c_o (contrib_a),
    .starve_c_o  (starve_a)
  );

  audio_src_hold u_src_b (
    .clk_i       (iCLK),
    .rst_i       (iRST),
    .en_i        (iEN_B),
    .valid_i     (iVALID_B),
    .l_i         (iL_B),
    .r_i         (iR_B),
    .load_i      (load),
    .ready_c_o   (oREADY_B),
    .contrib_c_o (contrib_b),
    .starve_c_o  (starve_b)
  );

  assign div_wrap  = (div_cnt_q == DIV_W'(CLK_DIV - 1));
  assign fall_tick = div_wrap & bclk_q;
  assign bit_wrap  = (bit_cnt_q == BIT_W'(SLOT_BITS - 1));
  assign next_bit  = bit_wrap ? '0 : bit_cnt_q + BIT_W'(1);
  assign load      = fall_tick & bit_wrap & lrck_q;
  assign mix_l     = sat_add(contrib_a.l, contrib_b.l);
  assign mix_r     = sat_add(contrib_a.r, contrib_b.r);

  always_comb begin
    div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
    bclk_d    = div_wrap ? ~bclk_q : bclk_q;
    bit_cnt_d = bit_cnt_q;
    lrck_d    = lrck_q;
    dat_d     = dat_q;
    shift_d   = shift_q;
    right_d   = right_q;
    frame_d   = load;
    urun_d    = urun_q;
    // Slot bit 0 is the I2S delay bit; the word follows MSB-first, then zero padding.
    if (fall_tick) begin
      bit_cnt_d = next_bit;
      dat_d     = 1'b0;
      if (bit_wrap) begin
        lrck_d = ~lrck_q;
        if (lrck_q) begin
          shift_d = mix_l;
          right_d = mix_r;
        end else begin
          shift_d = right_q;
        end
      end else if (next_bit <= BIT_W'(DATA_WIDTH)) begin
        dat_d   = shift_q[DATA_WIDTH-1];
        shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
      end
    end
    if (load && (starve_a || starve_b)) begin
      urun_d = 1'b1;
    end else if (iCLR_ERR) begin
      urun_d = 1'b0;
    end
  end

  // LRCK and bit counter reset to the end of a right slot so the first fall tick loads a frame.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      div_cnt_q <= '0;
      bit_cnt_q <= BIT_W'(SLOT_BITS - 1);
      bclk_q    <= 1'b0;
      lrck_q    <= 1'b1;
      dat_q     <= 1'b0;
      frame_q   <= 1'b0;
      urun_q    <= 1'b0;
      shift_q   <= '0;
      right_q   <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q    <= bclk_d;
      lrck_q    <= lrck_d;
      dat_q     <= dat_d;
      frame_q   <= frame_d;
      urun_q    <= urun_d;
      shift_q   <= shift_d;
      right_q   <= right_d;
    end
  end

  assign oBCLK     = bclk_q;
  assign oLRCK     = lrck_q;
  assign oDAT      = dat_q;
  assign oFRAME    = frame_q;
  assign oUNDERRUN = urun_q;

endmodule
